// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the cache-line pattern scan controller.
package pattern_scan_pkg;

    localparam int CL_SIZE    = 64;
    localparam int WORDS      = CL_SIZE / 4;
    localparam int LINE_BYTES = 64;
    localparam int LINE_W     = CL_SIZE * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_TRIG,
        S_EVAL,
        S_HIT2
    } state_t;

    function automatic logic size_legal(input logic [4:0] size);
        return (size != 5'd0) && (size <= 5'(WORDS));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_match_pattern.sv
// Line matcher: finds the lowest word offset where the pattern, or the prefix
// of it that still fits in the line, lines up with the line contents.
module match_pattern
    import pattern_scan_pkg::*;
(
    input  logic              i_trigger,
    input  logic [LINE_W-1:0] i_line,
    input  logic [LINE_W-1:0] i_pattern,
    input  logic [4:0]        i_size,
    output logic              o_full_match,
    output logic              o_partial_match,
    output logic [3:0]        o_offset
);

    logic [WORDS-1:0] at_off;

    // at_off[k]: line words k.. equal pattern words 0.. for min(size, 16-k) words
    always_comb begin
        at_off = '0;
        for (int k = 0; k < WORDS; k++) begin
            at_off[k] = 1'b1;
            for (int j = 0; j < WORDS; j++) begin
                if (j < int'(i_size) && k + j < WORDS &&
                    i_line[((k + j) % WORDS) * 32 +: 32] != i_pattern[j * 32 +: 32])
                    at_off[k] = 1'b0;
            end
        end
    end

    always_comb begin
        o_offset = 4'd0;
        for (int k = WORDS - 1; k >= 1; k--) begin
            if (at_off[k])
                o_offset = 4'(k);
        end
    end

    assign o_full_match    = i_trigger && at_off[0];
    assign o_partial_match = i_trigger && !at_off[0] && (|at_off[WORDS-1:1]);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencing controller for the cache-line pattern matcher, including
// continuation of matches that spill over into the next contiguous line.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int ADDR_W = 40
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [LINE_W-1:0] i_pattern,
    input  logic [4:0]        i_pattern_size,
    input  logic              i_cl_valid,
    output logic              o_cl_ready,
    input  logic [LINE_W-1:0] i_cl_data,
    input  logic [ADDR_W-1:0] i_cl_addr,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_hit_addr,
    output logic [3:0]        o_hit_offset,
    output logic              o_hit_split,
    output logic [15:0]       o_hit_count,
    output logic              o_cfg_err,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    state_t            state_q;
    logic [LINE_W-1:0] line_q, pat_q;
    logic [ADDR_W-1:0] addr_q, exp_addr_q, base_addr_q, own_addr_q, hit_addr_q;
    logic [4:0]        size_q, cont_m_q;
    logic [3:0]        base_off_q, own_off_q, hit_off_q;
    logic              cont_pend_q, own_pend_q, hit_q, hit_split_q, cfg_err_q;
    logic [15:0]       count_q;

    logic              trig, full_m, part_m;
    logic [3:0]        part_off;
    logic [LINE_W-1:0] pat_shift;
    logic [WORDS-1:0]  cont_eq, cont_mask;
    logic              cont_ok_d, own_hit_d, new_cont_d;
    logic [3:0]        own_off_d;
    logic [4:0]        tail_words_d;

    assign trig = (state_q == S_TRIG);

    match_pattern u_match (
        .i_trigger       (trig),
        .i_line          (line_q),
        .i_pattern       (pat_q),
        .i_size          (size_q),
        .o_full_match    (full_m),
        .o_partial_match (part_m),
        .o_offset        (part_off)
    );

    // Continuation: line words 0..size-m-1 against pattern words m..size-1
    assign pat_shift = pat_q >> {cont_m_q, 5'd0};

    for (genvar w = 0; w < WORDS; w++) begin : g_cont
        assign cont_mask[w] = 5'(w) < (size_q - cont_m_q);
        assign cont_eq[w]   = line_q[w*32 +: 32] == pat_shift[w*32 +: 32];
    end

    assign cont_ok_d = cont_pend_q && size_legal(size_q) && (size_q > cont_m_q) &&
                       (addr_q == exp_addr_q) && (&(cont_eq | ~cont_mask));

    assign tail_words_d = 5'(WORDS) - {1'b0, part_off};

    always_comb begin
        own_hit_d  = 1'b0;
        own_off_d  = 4'd0;
        new_cont_d = 1'b0;
        if (size_legal(size_q)) begin
            if (full_m) begin
                own_hit_d = 1'b1;
            end else if (part_m) begin
                own_off_d = part_off;
                if (size_q <= tail_words_d)
                    own_hit_d = 1'b1;
                else
                    new_cont_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            pat_q       <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            cont_pend_q <= 1'b0;
            exp_addr_q  <= '0;
            cont_m_q    <= '0;
            base_addr_q <= '0;
            base_off_q  <= '0;
            own_pend_q  <= 1'b0;
            own_addr_q  <= '0;
            own_off_q   <= '0;
            hit_q       <= 1'b0;
            hit_addr_q  <= '0;
            hit_off_q   <= '0;
            hit_split_q <= 1'b0;
            count_q     <= '0;
            cfg_err_q   <= 1'b0;
        end else if (!i_enable) begin
            state_q     <= S_IDLE;
            cont_pend_q <= 1'b0;
            own_pend_q  <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                S_IDLE, S_PEND: begin
                    if (i_cl_valid) begin
                        line_q    <= i_cl_data;
                        addr_q    <= i_cl_addr & LINE_MASK;
                        pat_q     <= i_pattern;
                        size_q    <= i_pattern_size;
                        cfg_err_q <= !size_legal(i_pattern_size);
                        state_q   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    // Outputs are registered here so the pulse is visible during EVAL.
                    cont_pend_q <= new_cont_d;
                    if (new_cont_d) begin
                        exp_addr_q  <= addr_q + ADDR_W'(LINE_BYTES);
                        cont_m_q    <= tail_words_d;
                        base_addr_q <= addr_q;
                        base_off_q  <= own_off_d;
                    end
                    if (cont_ok_d) begin
                        hit_q       <= 1'b1;
                        hit_addr_q  <= base_addr_q;
                        hit_off_q   <= base_off_q;
                        hit_split_q <= 1'b1;
                        count_q     <= sat_inc(count_q);
                        own_pend_q  <= own_hit_d;
                        own_addr_q  <= addr_q;
                        own_off_q   <= own_off_d;
                    end else if (own_hit_d) begin
                        hit_q       <= 1'b1;
                        hit_addr_q  <= addr_q;
                        hit_off_q   <= own_off_d;
                        hit_split_q <= 1'b0;
                        count_q     <= sat_inc(count_q);
                    end
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (own_pend_q) begin
                        hit_q       <= 1'b1;
                        hit_addr_q  <= own_addr_q;
                        hit_off_q   <= own_off_q;
                        hit_split_q <= 1'b0;
                        count_q     <= sat_inc(count_q);
                        own_pend_q  <= 1'b0;
                        state_q     <= S_HIT2;
                    end else begin
                        state_q <= cont_pend_q ? S_PEND : S_IDLE;
                    end
                end
                S_HIT2: state_q <= cont_pend_q ? S_PEND : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cl_ready   = i_enable && !i_rst && (state_q == S_IDLE || state_q == S_PEND);
    assign o_hit        = hit_q;
    assign o_hit_addr   = hit_addr_q;
    assign o_hit_offset = hit_off_q;
    assign o_hit_split  = hit_split_q;
    assign o_hit_count  = count_q;
    assign o_cfg_err    = cfg_err_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a word-array reference model.
module tb_pattern_scan_ctrl;

    localparam int AW = 40;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_enable = 1'b1;
    logic [511:0]    i_pattern = '0;
    logic [4:0]      i_pattern_size = 5'd4;
    logic            i_cl_valid = 1'b0;
    logic            o_cl_ready;
    logic [511:0]    i_cl_data = '0;
    logic [AW-1:0]   i_cl_addr = '0;
    logic            o_hit;
    logic [AW-1:0]   o_hit_addr;
    logic [3:0]      o_hit_offset;
    logic            o_hit_split;
    logic [15:0]     o_hit_count;
    logic            o_cfg_err;
    logic            o_busy;

    pattern_scan_ctrl #(.ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_pattern(i_pattern), .i_pattern_size(i_pattern_size),
        .i_cl_valid(i_cl_valid), .o_cl_ready(o_cl_ready),
        .i_cl_data(i_cl_data), .i_cl_addr(i_cl_addr),
        .o_hit(o_hit), .o_hit_addr(o_hit_addr), .o_hit_offset(o_hit_offset),
        .o_hit_split(o_hit_split), .o_hit_count(o_hit_count),
        .o_cfg_err(o_cfg_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected pulses keyed by cycle, plus continuation state.
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        int            off;
        bit            split;
    } ev_t;

    ev_t           expq[$];
    int            exp_cnt = 0;
    bit            chk_en = 1'b0;
    bit            m_cont = 1'b0;
    logic [AW-1:0] m_exp, m_base;
    int            m_m, m_off;

    task automatic push(input int c, input logic [AW-1:0] a, input int off, input bit split);
        ev_t e;
        e.cyc = c; e.addr = a; e.off = off; e.split = split;
        expq.push_back(e);
    endtask

    task automatic model_accept(input int n);
        logic [31:0]   lw[16];
        logic [31:0]   pw[16];
        int            sz;
        logic [AW-1:0] a;
        bit            had;
        int            slot;
        bit            ok;
        int            len;
        sz   = int'(i_pattern_size);
        a    = i_cl_addr & ~AW'(63);
        had  = m_cont;
        slot = n + 2;
        m_cont = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lw[i] = i_cl_data[i*32 +: 32];
            pw[i] = i_pattern[i*32 +: 32];
        end
        if (sz < 1 || sz > 16) return;
        if (had && a == m_exp && sz > m_m) begin
            ok = 1'b1;
            for (int j = 0; j < sz - m_m; j++)
                if (lw[j] != pw[m_m + j]) ok = 1'b0;
            if (ok) begin
                push(slot, m_base, m_off, 1'b1);
                slot++;
            end
        end
        for (int k = 0; k < 16; k++) begin
            ok  = 1'b1;
            len = (sz < 16 - k) ? sz : 16 - k;
            for (int j = 0; j < len; j++)
                if (lw[k + j] != pw[j]) ok = 1'b0;
            if (ok) begin
                if (k + sz <= 16) push(slot, a, k, 1'b0);
                else begin
                    m_cont = 1'b1; m_exp = a + AW'(64); m_m = 16 - k;
                    m_base = a; m_off = k;
                end
                break;
            end
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                chk("late_pulse", 64'(expq[0].cyc), 64'(cyc));
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                exp_cnt++;
                chk("hit", 64'(o_hit), 64'd1);
                chk("hit_addr", 64'(o_hit_addr), 64'(expq[0].addr));
                chk("hit_offset", 64'(o_hit_offset), 64'(expq[0].off));
                chk("hit_split", 64'(o_hit_split), 64'(expq[0].split));
                void'(expq.pop_front());
            end else begin
                chk("no_hit", 64'(o_hit), 64'd0);
            end
            chk("hit_count", 64'(o_hit_count), 64'(exp_cnt));
        end
    end

    function automatic logic [31:0] pw(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [511:0] filler(input int seed);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'h5000_0000 | 32'(seed << 8) | 32'(i);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [511:0] line, input logic [AW-1:0] addr);
        int waitc;
        waitc = 0;
        i_cl_data  = line;
        i_cl_addr  = addr;
        i_cl_valid = 1'b1;
        while (!o_cl_ready) begin
            @(negedge i_clk);
            waitc++;
            if (waitc > 50) begin
                checks++; failures++;
                $display("FAIL accept_timeout: ready never seen for addr %0h", addr);
                i_cl_valid = 1'b0;
                return;
            end
        end
        model_accept(cyc);
        @(negedge i_clk);
        i_cl_valid = 1'b0;
    endtask

    logic [511:0] ln;

    initial begin
        for (int i = 0; i < 16; i++) i_pattern[i*32 +: 32] = pw(i);
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 64'(o_cl_ready), 64'd0);
        chk("rst_hit", 64'(o_hit), 64'd0);
        chk("rst_count", 64'(o_hit_count), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_cfg_err", 64'(o_cfg_err), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_en = 1'b1;
        chk("idle_ready", 64'(o_cl_ready), 64'd1);

        // Size 4, words 0..3 match
        i_pattern_size = 5'd4;
        ln = filler(1);
        for (int i = 0; i < 4; i++) ln[i*32 +: 32] = pw(i);
        send(ln, 40'h1000);
        chk("t1_busy_trig", 64'(o_busy), 64'd1);
        chk("t1_ready_trig", 64'(o_cl_ready), 64'd0);
        @(negedge i_clk);
        chk("t1_hit", 64'(o_hit), 64'd1);
        chk("t1_off", 64'(o_hit_offset), 64'd0);
        chk("t1_count", 64'(o_hit_count), 64'd1);
        @(negedge i_clk);
        chk("t1_ready_back", 64'(o_cl_ready), 64'd1);

        // Size 3 aligned tail at 13
        i_pattern_size = 5'd3;
        ln = filler(2);
        for (int i = 0; i < 3; i++) ln[(13 + i)*32 +: 32] = pw(i);
        send(ln, 40'h2040);
        @(negedge i_clk);
        chk("t2_off", 64'(o_hit_offset), 64'd13);
        chk("t2_split", 64'(o_hit_split), 64'd0);
        @(negedge i_clk);
        chk("t2_not_pending", 64'(o_busy), 64'd0);

        // Size 6 split across 0x3000 / 0x3040
        i_pattern_size = 5'd6;
        ln = filler(3);
        for (int i = 0; i < 4; i++) ln[(12 + i)*32 +: 32] = pw(i);
        send(ln, 40'h3000);
        repeat (2) @(negedge i_clk);
        chk("t3_pending_busy", 64'(o_busy), 64'd1);
        ln = filler(4);
        ln[0 +: 32] = pw(4); ln[32 +: 32] = pw(5);
        send(ln, 40'h3040);
        @(negedge i_clk);
        chk("t3_split", 64'(o_hit_split), 64'd1);
        chk("t3_addr", 64'(o_hit_addr), 64'h3000);
        chk("t3_off", 64'(o_hit_offset), 64'd12);

        // Non-contiguous second line drops the continuation
        ln = filler(3);
        for (int i = 0; i < 4; i++) ln[(12 + i)*32 +: 32] = pw(i);
        send(ln, 40'h4000);
        ln = filler(4);
        ln[0 +: 32] = pw(4); ln[32 +: 32] = pw(5);
        send(ln, 40'h4080);
        repeat (2) @(negedge i_clk);
        chk("t4_idle", 64'(o_busy), 64'd0);
        chk("t4_count", 64'(o_hit_count), 64'd3);

        // Continuation hit plus own full match: EVAL then HIT2
        i_pattern[4*32 +: 32] = pw(0);
        i_pattern[5*32 +: 32] = pw(1);
        ln = filler(5);
        for (int i = 0; i < 4; i++) ln[(12 + i)*32 +: 32] = pw(i);
        send(ln, 40'h5000);
        ln = filler(6);
        for (int i = 0; i < 6; i++) ln[i*32 +: 32] = pw(i % 4);
        send(ln, 40'h5040);
        @(negedge i_clk);
        chk("t5_split_first", 64'(o_hit_split), 64'd1);
        chk("t5_count_a", 64'(o_hit_count), 64'd4);
        @(negedge i_clk);
        chk("t5_hit2", 64'(o_hit), 64'd1);
        chk("t5_hit2_addr", 64'(o_hit_addr), 64'h5040);
        chk("t5_count_b", 64'(o_hit_count), 64'd5);
        chk("t5_ready_hit2", 64'(o_cl_ready), 64'd0);
        @(negedge i_clk);
        chk("t5_ready_back", 64'(o_cl_ready), 64'd1);
        for (int i = 0; i < 16; i++) i_pattern[i*32 +: 32] = pw(i);

        // Enable drop while a continuation is pending clears it
        ln = filler(7);
        for (int i = 0; i < 4; i++) ln[(12 + i)*32 +: 32] = pw(i);
        send(ln, 40'h6000);
        repeat (2) @(negedge i_clk);
        i_enable = 1'b0;
        m_cont = 1'b0;
        @(negedge i_clk);
        chk("t6_disabled_busy", 64'(o_busy), 64'd0);
        chk("t6_disabled_ready", 64'(o_cl_ready), 64'd0);
        i_enable = 1'b1;
        @(negedge i_clk);
        ln = filler(8);
        ln[0 +: 32] = pw(4); ln[32 +: 32] = pw(5);
        send(ln, 40'h6040);
        repeat (2) @(negedge i_clk);
        chk("t6_count", 64'(o_hit_count), 64'd5);

        // Address wrap, low address bits ignored
        ln = filler(9);
        for (int i = 0; i < 4; i++) ln[(12 + i)*32 +: 32] = pw(i);
        send(ln, 40'hFF_FFFF_FFC7);
        ln = filler(10);
        ln[0 +: 32] = pw(4); ln[32 +: 32] = pw(5);
        send(ln, 40'h15);
        @(negedge i_clk);
        chk("t7_wrap_addr", 64'(o_hit_addr), 64'hFF_FFFF_FFC0);
        chk("t7_wrap_split", 64'(o_hit_split), 64'd1);

        // Full 16-word pattern
        i_pattern_size = 5'd16;
        for (int i = 0; i < 16; i++) ln[i*32 +: 32] = pw(i);
        send(ln, 40'h8000);
        @(negedge i_clk);
        chk("t8_full16", 64'(o_hit_offset), 64'd0);
        chk("t8_count", 64'(o_hit_count), 64'd7);

        // Illegal sizes
        ln = filler(11);
        for (int i = 0; i < 4; i++) ln[(2 + i)*32 +: 32] = pw(i);
        i_pattern_size = 5'd0;
        send(ln, 40'h9000);
        chk("t9_cfg_err0", 64'(o_cfg_err), 64'd1);
        @(negedge i_clk);
        chk("t9_no_hit0", 64'(o_hit), 64'd0);
        i_pattern_size = 5'd17;
        send(ln, 40'h9000);
        chk("t9_cfg_err17", 64'(o_cfg_err), 64'd1);
        i_pattern_size = 5'd4;
        send(ln, 40'h9000);
        chk("t9_cfg_ok", 64'(o_cfg_err), 64'd0);
        @(negedge i_clk);
        chk("t9_off2", 64'(o_hit_offset), 64'd2);
        chk("t9_count", 64'(o_hit_count), 64'd8);

        // Reset while TRIG
        ln = filler(12);
        for (int i = 0; i < 4; i++) ln[i*32 +: 32] = pw(i);
        send(ln, 40'hA000);
        chk_en = 1'b0;
        expq.delete();
        exp_cnt = 0;
        m_cont = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t10_hit", 64'(o_hit), 64'd0);
        chk("t10_count", 64'(o_hit_count), 64'd0);
        chk("t10_addr", 64'(o_hit_addr), 64'd0);
        chk("t10_off", 64'(o_hit_offset), 64'd0);
        chk("t10_busy", 64'(o_busy), 64'd0);
        chk("t10_ready", 64'(o_cl_ready), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_en = 1'b1;

        // Normal operation after reset
        send(ln, 40'hB000);
        @(negedge i_clk);
        chk("t11_count", 64'(o_hit_count), 64'd1);

        repeat (4) @(negedge i_clk);
        chk("drain", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
